// File: rtl/bcd_timer.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_timer
//  Purpose  : Parametrised BCD up/down timer. A prescaler divides clk by DVSR
//             into count ticks. Each digit counts modulo 10 or modulo 6, as
//             selected by SIX_MASK. The timer supports wrap or saturate at the
//             boundary, a clamped preset load, and a registered terminal-count
//             pulse. It drives a packed, registered BCD digit bus.
//  Options  : BCD_TIMER_LAP_EN - when defined, builds the lap (display freeze)
//             capture register and its toggle logic. When undefined, lap_req
//             is ignored and lap_active is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_timer #(
  parameter int                DVSR     = 10000000,
  parameter int                N        = 24,
  parameter int                DIGITS   = 4,
  parameter logic [DIGITS-1:0] SIX_MASK = 4'b0100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  wrap,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  lap_req,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  tc,
  output logic                  lap_active
);

  localparam int              c_w      = 4 * DIGITS;
  localparam logic [N-1:0]    c_p_last = N'(DVSR - 1);
  localparam logic [N-1:0]    c_p_one  = N'(1);

  // Prescaler and tick
  logic [N-1:0]     r_p;
  logic             w_tick;

  // Live count and its next-state terms
  logic [c_w-1:0]   r_live;
  logic [c_w-1:0]   w_step;
  logic [c_w-1:0]   w_load_val;
  logic [DIGITS-1:0] w_is_max;
  logic [DIGITS-1:0] w_is_zero;
  logic [DIGITS-1:0] w_next_max;
  logic [DIGITS-1:0] w_next_zero;
  logic [DIGITS-1:0] w_roll;
  logic [DIGITS-1:0] w_carry;
  logic             w_at_bound;
  logic             w_hold;
  logic             w_next_term;
  logic             w_do_step;

  // Output stage
  logic [c_w-1:0]   w_display;
  logic [c_w-1:0]   r_digits;
  logic             r_tc_pend;
  logic             r_tc;

  assign w_tick = enable && (r_p == c_p_last);

  // Prescaler: free-runs while enabled, restarts on tick or load
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_p <= '0;
    end else if (load || w_tick) begin
      r_p <= '0;
    end else if (enable) begin
      r_p <= r_p + c_p_one;
    end
  end

  // The least significant digit always sees a step request on a tick
  assign w_carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      localparam logic [3:0] c_max = SIX_MASK[gi] ? 4'd5 : 4'd9;

      logic [3:0] w_cur;
      logic [3:0] w_nxt;
      logic [3:0] w_ld;

      assign w_cur = r_live[4*gi +: 4];
      assign w_ld  = load_value[4*gi +: 4];

      assign w_is_max[gi]  = (w_cur == c_max);
      assign w_is_zero[gi] = (w_cur == 4'd0);

      // A digit rolls when it sits at the edge of its range in the count direction
      assign w_roll[gi] = up ? w_is_max[gi] : w_is_zero[gi];

      // Digits only move when every lower digit rolled (ripple carry / borrow)
      assign w_nxt = !w_carry[gi] ? w_cur :
                     w_roll[gi]   ? (up ? 4'd0 : c_max) :
                     up           ? (w_cur + 4'd1) :
                                    (w_cur - 4'd1);

      assign w_step[4*gi +: 4]     = w_nxt;
      assign w_next_max[gi]        = (w_nxt == c_max);
      assign w_next_zero[gi]       = (w_nxt == 4'd0);

      // Out-of-range preset digits are clamped to the digit maximum
      assign w_load_val[4*gi +: 4] = (w_ld > c_max) ? c_max : w_ld;

      if (gi < DIGITS - 1) begin : g_carry
        assign w_carry[gi+1] = w_carry[gi] & w_roll[gi];
      end
    end
  endgenerate

  // The natural ripple already wraps to all-zero or all-max, so only saturation needs a hold
  assign w_at_bound  = up ? (&w_is_max) : (&w_is_zero);
  assign w_hold      = w_at_bound && !wrap;
  assign w_next_term = up ? (&w_next_max) : (&w_next_zero);
  assign w_do_step   = w_tick && !load && !w_hold;

  // Live counter: load wins over tick, saturation holds the value
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_live <= '0;
    end else if (load) begin
      r_live <= w_load_val;
    end else if (w_do_step) begin
      r_live <= w_step;
    end
  end

  // Terminal count is flagged at the step edge and presented with the digit update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tc_pend <= 1'b0;
      r_tc      <= 1'b0;
    end else begin
      r_tc_pend <= w_do_step && w_next_term;
      r_tc      <= r_tc_pend;
    end
  end

`ifdef BCD_TIMER_LAP_EN
  logic [c_w-1:0] r_frozen;
  logic           r_lap_active;
  logic           w_lap_next;
  logic [c_w-1:0] w_frozen_next;

  assign w_lap_next    = lap_req ? !r_lap_active : r_lap_active;
  assign w_frozen_next = (lap_req && !r_lap_active) ? r_live : r_frozen;

  // Lap toggle: capture the live count on entry, release on the second request
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lap_active <= 1'b0;
      r_frozen     <= '0;
    end else begin
      r_lap_active <= w_lap_next;
      r_frozen     <= w_frozen_next;
    end
  end

  // Using the post-edge lap state keeps digits and lap_active in the same cycle
  assign w_display  = w_lap_next ? w_frozen_next : r_live;
  assign lap_active = r_lap_active;
`else
  logic w_unused_lap;

  assign w_unused_lap = lap_req;
  assign w_display    = r_live;
  assign lap_active   = 1'b0;
`endif

  // Display register: one cycle behind the live count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_digits <= '0;
    end else begin
      r_digits <= w_display;
    end
  end

  assign digits = r_digits;
  assign tc     = r_tc;

endmodule
`default_nettype wire

// File: tb/tb_bcd_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_timer
//  Purpose  : Scoreboard bench for bcd_timer (DVSR=4, DIGITS=4, SIX_MASK=0100).
//             Stimulus pushes the expected output sequence; a monitor pops an
//             entry on every change of {digits, tc, lap_active} and checks the
//             value and the cycle distance from the previous change.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_timer;

  localparam int         DVSR     = 4;
  localparam int         N        = 3;
  localparam int         DIGITS   = 4;
  localparam logic [3:0] SIX_MASK = 4'b0100;
`ifdef BCD_TIMER_LAP_EN
  localparam bit         LAP      = 1'b1;
`else
  localparam bit         LAP      = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        up;
  logic        wrap;
  logic        load;
  logic [15:0] load_value;
  logic        lap_req;
  logic [15:0] digits;
  logic        tc;
  logic        lap_active;

  bcd_timer #(
    .DVSR     (DVSR),
    .N        (N),
    .DIGITS   (DIGITS),
    .SIX_MASK (SIX_MASK)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .up         (up),
    .wrap       (wrap),
    .load       (load),
    .load_value (load_value),
    .lap_req    (lap_req),
    .digits     (digits),
    .tc         (tc),
    .lap_active (lap_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    logic        t;
    logic        l;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic push(input logic [15:0] d, input logic t, input logic l, input int gap);
    exp_t e;
    e.d = d; e.t = t; e.l = l; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_start(input logic [15:0] v, input logic u, input logic w);
    up = u; wrap = w; enable = 1'b1;
    load = 1'b1; load_value = v;
    step(1);
    load = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (digits !== 16'h0000 || tc !== 1'b0 || lap_active !== 1'b0) begin
      errors++;
      $display("FAIL %s: got digits=%h tc=%b lap=%b, required digits=0000 tc=0 lap=0",
               name, digits, tc, lap_active);
    end
  endtask

  // Monitor: every output change consumes one expected entry
  initial begin : monitor
    logic [15:0] pd;
    logic        pt;
    logic        pl;
    int          last;
    exp_t        e;
    pd = 16'h0; pt = 1'b0; pl = 1'b0; last = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        pd = digits; pt = tc; pl = lap_active; last = cyc;
      end else if ({digits, tc, lap_active} !== {pd, pt, pl}) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got digits=%h tc=%b lap=%b, required no change",
                   digits, tc, lap_active);
        end else begin
          e = q.pop_front();
          if ({digits, tc, lap_active} !== {e.d, e.t, e.l}) begin
            errors++;
            $display("FAIL value: got digits=%h tc=%b lap=%b, required digits=%h tc=%b lap=%b",
                     digits, tc, lap_active, e.d, e.t, e.l);
          end
          if (e.gap != 0) begin
            checks++;
            if (cyc - last != e.gap) begin
              errors++;
              $display("FAIL timing at digits=%h: got gap=%0d cycles, required %0d",
                       e.d, cyc - last, e.gap);
            end
          end
        end
        pd = digits; pt = tc; pl = lap_active; last = cyc;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish by 100000 time units, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    reset_n = 1'b0; load = 1'b1; load_value = 16'h1234;
    enable = 1'b1; up = 1'b1; wrap = 1'b1; lap_req = 1'b0;

    // Reset overrides a simultaneous load
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_reset_state("reset_hold");
    end
    reset_n = 1'b1; load = 1'b0; enable = 1'b0;
    step(1);
    check_reset_state("reset_release");
    mon_en = 1'b1;

    // Up carry through the modulo-6 digit
    push(16'h0599, 1'b0, 1'b0, 0);
    push(16'h1000, 1'b0, 1'b0, 4);
    push(16'h1001, 1'b0, 1'b0, 4);
    load_start(16'h0599, 1'b1, 1'b1);
    step(8); enable = 1'b0; step(3);

    // Up boundary with wrap
    push(16'h9598, 1'b0, 1'b0, 0);
    push(16'h9599, 1'b1, 1'b0, 4);
    push(16'h9599, 1'b0, 1'b0, 1);
    push(16'h0000, 1'b0, 1'b0, 3);
    load_start(16'h9598, 1'b1, 1'b1);
    step(8); enable = 1'b0; step(3);

    // Up boundary with saturation: single tc, then hold
    push(16'h9598, 1'b0, 1'b0, 0);
    push(16'h9599, 1'b1, 1'b0, 4);
    push(16'h9599, 1'b0, 1'b0, 1);
    load_start(16'h9598, 1'b1, 1'b0);
    step(12); enable = 1'b0; step(3);

    // Down boundary with wrap
    push(16'h0001, 1'b0, 1'b0, 0);
    push(16'h0000, 1'b1, 1'b0, 4);
    push(16'h0000, 1'b0, 1'b0, 1);
    push(16'h9599, 1'b0, 1'b0, 3);
    load_start(16'h0001, 1'b0, 1'b1);
    step(8); enable = 1'b0; step(3);

    // Down boundary with saturation
    push(16'h0001, 1'b0, 1'b0, 0);
    push(16'h0000, 1'b1, 1'b0, 4);
    push(16'h0000, 1'b0, 1'b0, 1);
    load_start(16'h0001, 1'b0, 1'b0);
    step(12); enable = 1'b0; step(3);

    // Clamped load on the exact tick cycle, prescaler restarts
    push(16'h0010, 1'b0, 1'b0, 0);
    push(16'h9579, 1'b0, 1'b0, 4);
    push(16'h9580, 1'b0, 1'b0, 4);
    load_start(16'h0010, 1'b1, 1'b1);
    step(3);
    load = 1'b1; load_value = 16'hFA7C;
    step(1);
    load = 1'b0;
    step(4); enable = 1'b0; step(3);

    // Lap freeze and release across three ticks
    push(16'h0012, 1'b0, 1'b0, 0);
    if (LAP) begin
      push(16'h0012, 1'b0, 1'b1, 1);
      push(16'h0015, 1'b0, 1'b0, 11);
    end else begin
      push(16'h0013, 1'b0, 1'b0, 4);
      push(16'h0014, 1'b0, 1'b0, 4);
      push(16'h0015, 1'b0, 1'b0, 4);
    end
    load_start(16'h0012, 1'b1, 1'b1);
    step(1);
    lap_req = 1'b1;
    step(1);
    lap_req = 1'b0;
    step(10);
    lap_req = 1'b1; enable = 1'b0;
    step(1);
    lap_req = 1'b0;
    step(3);

    // Reset aborts an active lap
    if (LAP) push(16'h0015, 1'b0, 1'b1, 0);
    push(16'h0000, 1'b0, 1'b0, 0);
    lap_req = 1'b1;
    step(1);
    lap_req = 1'b0;
    step(2);
    reset_n = 1'b0; load = 1'b1; load_value = 16'h1234;
    step(2);
    check_reset_state("reset_abort_lap");
    reset_n = 1'b1; load = 1'b0;
    step(3);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
